// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared state encoding, array geometry and element indexing for the matmul sequencer
package sa_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, WAIT_DONE, DONE} state_t;
    localparam int SA_N = 3;
    localparam int FEED_STEPS = 5;
    function automatic logic [3:0] idx(input int row, input int col);
        return 4'(row * SA_N + col);
    endfunction
endpackage

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: steps t=0..4 after load and drives registered skewed row/column feeds from the banks
module sa_skew_feeder
    import sa_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load,
    input  logic [SA_N*SA_N-1:0][DATAWIDTH-1:0]     a_bank,
    input  logic [SA_N*SA_N-1:0][DATAWIDTH-1:0]     b_bank,
    output logic                                    last,
    output logic [SA_N-1:0][DATAWIDTH-1:0]          sa_a,
    output logic [SA_N-1:0][DATAWIDTH-1:0]          sa_b
);
    logic                           active;
    logic                           feed;
    logic [2:0]                     t;
    logic [2:0]                     nt;
    logic [SA_N-1:0][DATAWIDTH-1:0] na;
    logic [SA_N-1:0][DATAWIDTH-1:0] nb;

    function automatic logic [DATAWIDTH-1:0] pick(input logic [SA_N*SA_N-1:0][DATAWIDTH-1:0] bank,
                                                  input int r, input int c);
        if (r < 0 || r >= SA_N || c < 0 || c >= SA_N) return '0;
        return bank[idx(r, c)];
    endfunction

    assign last = active && t == 3'(FEED_STEPS - 1);
    assign feed = load || (active && !last);
    assign nt   = load ? 3'd0 : t + 3'd1;

    // Feed values for the step presented next cycle; row i lags by i, column j lags by j
    always_comb begin
        na = '0;
        nb = '0;
        for (int i = 0; i < SA_N; i++) begin
            na[i] = feed ? pick(a_bank, i, int'(nt) - i) : '0;
            nb[i] = feed ? pick(b_bank, int'(nt) - i, i) : '0;
        end
    end

    // Step counter and registered feeds; feeds fall to 0 once the last step has been shown
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            t      <= '0;
            sa_a   <= '0;
            sa_b   <= '0;
        end else begin
            sa_a   <= na;
            sa_b   <= nb;
            active <= feed;
            t      <= feed ? nt : '0;
        end
    end
endmodule

// File: rtl/sa_matmul_sequencer.sv
// sa_matmul_sequencer: holds operand banks, runs one skewed 3x3 array job and captures its results
module sa_matmul_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [3:0]               wr_addr,
    input  logic [DATAWIDTH-1:0]     wr_data,
    input  logic                     go,
    input  logic [3:0]               rd_addr,
    output logic [2*DATAWIDTH-1:0]   rd_data,
    output logic                     busy,
    output logic                     out_valid,
    output logic                     err,
    output logic                     wr_drop,
    output logic                     sa_start,
    output logic [DATAWIDTH-1:0]     sa_A0,
    output logic [DATAWIDTH-1:0]     sa_A1,
    output logic [DATAWIDTH-1:0]     sa_A2,
    output logic [DATAWIDTH-1:0]     sa_B0,
    output logic [DATAWIDTH-1:0]     sa_B1,
    output logic [DATAWIDTH-1:0]     sa_B2,
    input  logic [2*DATAWIDTH-1:0]   sa_P11,
    input  logic [2*DATAWIDTH-1:0]   sa_P12,
    input  logic [2*DATAWIDTH-1:0]   sa_P13,
    input  logic [2*DATAWIDTH-1:0]   sa_P21,
    input  logic [2*DATAWIDTH-1:0]   sa_P22,
    input  logic [2*DATAWIDTH-1:0]   sa_P23,
    input  logic [2*DATAWIDTH-1:0]   sa_P31,
    input  logic [2*DATAWIDTH-1:0]   sa_P32,
    input  logic [2*DATAWIDTH-1:0]   sa_P33,
    input  logic                     sa_Done
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                                     state;
    logic [CW-1:0]                              cnt;
    logic [SA_N*SA_N-1:0][DATAWIDTH-1:0]        a_bank;
    logic [SA_N*SA_N-1:0][DATAWIDTH-1:0]        b_bank;
    logic [SA_N*SA_N-1:0][2*DATAWIDTH-1:0]      c_bank;
    logic [SA_N-1:0][DATAWIDTH-1:0]             sa_a;
    logic [SA_N-1:0][DATAWIDTH-1:0]             sa_b;
    logic                                       feed_last;
    logic                                       idle_like;

    assign idle_like = state == IDLE || state == DONE;
    assign rd_data   = rd_addr < 4'd9 ? c_bank[rd_addr] : '0;
    assign {sa_A2, sa_A1, sa_A0} = sa_a;
    assign {sa_B2, sa_B1, sa_B0} = sa_b;

    sa_skew_feeder #(.DATAWIDTH(DATAWIDTH)) u_feed (
        .clk    (CLK),
        .rst    (RST),
        .load   (state == CLEAR),
        .a_bank (a_bank),
        .b_bank (b_bank),
        .last   (feed_last),
        .sa_a   (sa_a),
        .sa_b   (sa_b)
    );

    // Job FSM with bank writes, result capture, timeout and registered status/start
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            wr_drop   <= 1'b0;
            sa_start  <= 1'b0;
            a_bank    <= '0;
            b_bank    <= '0;
            c_bank    <= '0;
        end else begin
            if (wr_en && idle_like && wr_addr < 4'd9) begin
                if (wr_sel) b_bank[wr_addr] <= wr_data;
                else a_bank[wr_addr] <= wr_data;
            end
            if (wr_en && !idle_like) wr_drop <= 1'b1;
            case (state)
                IDLE, DONE: if (go) begin
                    state     <= CLEAR;
                    busy      <= 1'b1;
                    out_valid <= 1'b0;
                    err       <= 1'b0;
                    wr_drop   <= 1'b0;
                    sa_start  <= 1'b0;
                end
                CLEAR: begin
                    state    <= FEED;
                    sa_start <= 1'b1;
                end
                FEED: if (feed_last) state <= FLUSH;
                FLUSH: begin
                    state <= WAIT_DONE;
                    cnt   <= '0;
                end
                WAIT_DONE: begin
                    if (sa_Done) begin
                        c_bank    <= {sa_P33, sa_P32, sa_P31, sa_P23, sa_P22, sa_P21, sa_P13, sa_P12, sa_P11};
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        sa_start  <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        err       <= 1'b1;
                        sa_start  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_matmul_sequencer.sv
// tb_sa_matmul_sequencer: directed bench around a behavioural 3x3 systolic array
module tb_sa_matmul_sequencer;
    logic        clk = 1'b0;
    logic        rst, wr_en, wr_sel, go;
    logic [3:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_data;
    logic        busy, out_valid, err, wr_drop, sa_start, sa_done;
    logic [7:0]  fa [3];
    logic [7:0]  fb [3];
    logic [15:0] p [9];
    logic [7:0]  ar [3][3];
    logic [7:0]  br [3][3];
    logic [15:0] acc [3][3];
    int          cyc;
    bit          stub = 1'b0;
    bit          fast = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int mm[9]   = '{3, 4, 2, 2, 5, 3, 3, 2, 5};
    int mm2[9]  = '{23, 36, 28, 25, 39, 34, 28, 32, 37};
    int eye[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int zero[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int mm7[9]  = '{3, 4, 2, 2, 7, 3, 3, 2, 5};
    int a0x[5]  = '{3, 4, 2, 0, 0};
    int b1x[5]  = '{0, 4, 5, 2, 0};

    always #5 clk = ~clk;

    sa_matmul_sequencer #(.DATAWIDTH(8), .TIMEOUT(32)) dut (
        .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .out_valid(out_valid), .err(err),
        .wr_drop(wr_drop), .sa_start(sa_start),
        .sa_A0(fa[0]), .sa_A1(fa[1]), .sa_A2(fa[2]), .sa_B0(fb[0]), .sa_B1(fb[1]), .sa_B2(fb[2]),
        .sa_P11(p[0]), .sa_P12(p[1]), .sa_P13(p[2]), .sa_P21(p[3]), .sa_P22(p[4]), .sa_P23(p[5]),
        .sa_P31(p[6]), .sa_P32(p[7]), .sa_P33(p[8]), .sa_Done(sa_done)
    );

    function automatic logic [7:0] ain(int i, int j);
        return j == 0 ? fa[i] : ar[i][j == 0 ? 0 : j - 1];
    endfunction

    function automatic logic [7:0] bin(int i, int j);
        return i == 0 ? fb[j] : br[i == 0 ? 0 : i - 1][j];
    endfunction

    // Output-stationary array: operands move right/down, cleared whenever start is low
    always @(posedge clk) begin
        if (sa_start !== 1'b1) begin
            cyc <= 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    ar[i][j]  <= ain(i, j);
                    br[i][j]  <= bin(i, j);
                    acc[i][j] <= acc[i][j] + 16'(ain(i, j)) * 16'(bin(i, j));
                end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) p[k] = acc[k / 3][k % 3];
    end

    assign sa_done = fast ? sa_start : (!stub && sa_start && cyc >= 7);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(bit sel, int addr, int data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(bit sel, int m[9]);
        for (int k = 0; k < 9; k++) wr(sel, k, m[k]);
    endtask

    task automatic read(int k);
        rd_addr = 4'(k);
        @(negedge clk);
    endtask

    task automatic check_c(string tag, int m[9]);
        for (int k = 0; k < 9; k++) begin
            read(k);
            check($sformatf("%s[%0d]", tag, k), 32'(rd_data), 32'(m[k]));
        end
    endtask

    task automatic start_job();
        go = 1'b1;
        step();
        go = 1'b0;
        lat = 1;
    endtask

    task automatic wait_valid();
        while (out_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; rd_addr = '0;
        step();
        step();
        check("reset busy", 32'(busy), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset err", 32'(err), 0);
        check("reset wr_drop", 32'(wr_drop), 0);
        check("reset sa_start", 32'(sa_start), 0);
        check("reset rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        load(1'b0, mm);
        load(1'b1, mm);
        start_job();
        check("clear busy", 32'(busy), 1);
        check("clear sa_start", 32'(sa_start), 0);
        for (int t = 0; t < 5; t++) begin
            step();
            lat++;
            check($sformatf("feed sa_A0 t%0d", t), 32'(fa[0]), 32'(a0x[t]));
            check($sformatf("feed sa_B1 t%0d", t), 32'(fb[1]), 32'(b1x[t]));
        end
        check("feed sa_start", 32'(sa_start), 1);
        step();
        lat++;
        check("flush sa_start", 32'(sa_start), 1);
        check("flush feeds", 32'(fa[0] | fa[1] | fa[2] | fb[0] | fb[1] | fb[2]), 0);
        wait_valid();
        check("job1 latency", 32'(lat), 10);
        check("job1 busy", 32'(busy), 0);
        check("job1 err", 32'(err), 0);
        check("job1 sa_start", 32'(sa_start), 0);
        check_c("job1 C", mm2);
        read(12);
        check("rd_addr 12", 32'(rd_data), 0);

        load(1'b0, eye);
        start_job();
        check("rerun out_valid drop", 32'(out_valid), 0);
        check("rerun busy", 32'(busy), 1);
        wait_valid();
        check("identity latency", 32'(lat), 10);
        check_c("identity C", mm);

        stub = 1'b1;
        start_job();
        while (out_valid !== 1'b1 && lat < 200) begin
            go = (lat == 20);
            step();
            lat++;
            if (lat == 21) check("ignored go start", 32'(sa_start), 1);
        end
        go = 1'b0;
        stub = 1'b0;
        check("timeout latency", 32'(lat), 40);
        check("timeout err", 32'(err), 1);
        check("timeout busy", 32'(busy), 0);
        read(0);
        check("timeout C[0] kept", 32'(rd_data), 3);
        read(4);
        check("timeout C[4] kept", 32'(rd_data), 5);

        load(1'b0, mm);
        start_job();
        check("accept clears err", 32'(err), 0);
        step();
        step();
        lat += 2;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
        step();
        lat++;
        wr_en = 1'b0;
        check("busy write wr_drop", 32'(wr_drop), 1);
        wait_valid();
        check("dropped-write latency", 32'(lat), 10);
        check_c("dropped-write C", mm2);

        start_job();
        check("accept clears wr_drop", 32'(wr_drop), 0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midjob rst busy", 32'(busy), 0);
        check("midjob rst out_valid", 32'(out_valid), 0);
        check("midjob rst sa_start", 32'(sa_start), 0);
        check("midjob rst feeds", 32'(fa[0] | fa[1] | fa[2] | fb[0] | fb[1] | fb[2]), 0);
        check("midjob rst err", 32'(err), 0);
        read(0);
        check("midjob rst C[0]", 32'(rd_data), 0);
        start_job();
        wait_valid();
        check("zero-bank latency", 32'(lat), 10);
        check_c("zero-bank C", zero);

        load(1'b0, eye);
        load(1'b1, mm);
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd4; wr_data = 8'd7;
        start_job();
        wr_en = 1'b0;
        check("write with go wr_drop", 32'(wr_drop), 0);
        wait_valid();
        check_c("write with go C", mm7);

        fast = 1'b1;
        start_job();
        wait_valid();
        fast = 1'b0;
        check("min latency", 32'(lat), 9);
        check("min latency err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
